// File: rtl/sap_instruction_register_v2_pkg.sv
// Shared SAP definitions: instruction-register states, default widths and the
// opcode length decode that the controller also uses.
package sap_pkg;

    localparam int unsigned SAP_DATA_W   = 8;
    localparam int unsigned SAP_OPCODE_W = 8;

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_ARG = 2'd1,
        HOLD      = 2'd2
    } ir_state_t;

    // Operand words that follow an opcode, from its top two bits, capped at max_ops.
    function automatic int unsigned op_len(input logic [1:0] top_bits, input int unsigned max_ops);
        int unsigned n;
        case (top_bits)
            2'b00:   n = 32'd0;
            2'b01:   n = 32'd1;
            default: n = 32'd2;
        endcase
        if (n > max_ops) begin
            n = max_ops;
        end else begin
            n = n;
        end
        return n;
    endfunction

endpackage

// File: rtl/sap_instruction_register_v2.sv
// Variable-length SAP instruction register: fetches an opcode word plus its operand
// words, holds them for the controller and drives a selected operand back to the bus.
module sap_instruction_register_v2
    import sap_pkg::*;
#(
    parameter int unsigned DATA_W       = SAP_DATA_W,
    parameter int unsigned OPCODE_W     = SAP_OPCODE_W,
    parameter int unsigned MAX_OPERANDS = 2,
    localparam int unsigned SEL_W       = (MAX_OPERANDS > 1) ? $clog2(MAX_OPERANDS) : 1,
    localparam int unsigned CNT_W       = $clog2(MAX_OPERANDS + 1)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [DATA_W-1:0]                w_bus_in,
    input  logic                             load_valid,
    output logic                             load_ready,
    input  logic                             instr_done,
    input  logic                             output_to_bus,
    input  logic [SEL_W-1:0]                 operand_sel,
    output logic [OPCODE_W-1:0]              opcode,
    output logic [MAX_OPERANDS*DATA_W-1:0]   operands,
    output logic [CNT_W-1:0]                 operand_count,
    output logic                             instr_valid,
    output logic [DATA_W-1:0]                w_bus_out,
    output logic                             w_bus_oe
);

    ir_state_t                        state_r;
    ir_state_t                        state_next_s;
    logic [SEL_W-1:0]                 idx_r;
    logic [CNT_W-1:0]                 count_r;
    logic [OPCODE_W-1:0]              opcode_r;
    logic [MAX_OPERANDS*DATA_W-1:0]   operands_r;
    logic [DATA_W-1:0]                bus_out_r;
    logic                             bus_oe_r;
    logic                             accept_s;
    logic                             last_arg_s;
    logic [CNT_W-1:0]                 len_s;
    logic                             oe_next_s;
    logic [DATA_W-1:0]                out_next_s;

    assign load_ready    = (state_r != HOLD);
    assign instr_valid   = (state_r == HOLD);
    assign accept_s      = load_valid && load_ready && !flush;
    // Opcode length uses the top two opcode bits; OPCODE_W is assumed to be at least 2.
    assign len_s         = CNT_W'(op_len(w_bus_in[OPCODE_W-1 -: 2], MAX_OPERANDS));
    assign last_arg_s    = ((32'(idx_r) + 32'd1) == 32'(count_r));
    assign opcode        = opcode_r;
    assign operands      = operands_r;
    assign operand_count = count_r;
    assign w_bus_out     = bus_out_r;
    assign w_bus_oe      = bus_oe_r;

    // Next-state decode; flush overrides every state.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = FETCH_OP;
        end else begin
            case (state_r)
                FETCH_OP: begin
                    if (accept_s) begin
                        state_next_s = (len_s == {CNT_W{1'b0}}) ? HOLD : FETCH_ARG;
                    end else begin
                        state_next_s = FETCH_OP;
                    end
                end
                FETCH_ARG: begin
                    if (accept_s && last_arg_s) begin
                        state_next_s = HOLD;
                    end else begin
                        state_next_s = FETCH_ARG;
                    end
                end
                HOLD: begin
                    if (instr_done) begin
                        state_next_s = FETCH_OP;
                    end else begin
                        state_next_s = HOLD;
                    end
                end
                default: state_next_s = FETCH_OP;
            endcase
        end
    end

    // Bus drive for the following cycle; out-of-range selects drive nothing.
    always_comb begin
        oe_next_s  = 1'b0;
        out_next_s = {DATA_W{1'b0}};
        if (output_to_bus && (state_r == HOLD) && (32'(operand_sel) < 32'(count_r))) begin
            oe_next_s  = 1'b1;
            out_next_s = operands_r[32'(operand_sel)*DATA_W +: DATA_W];
        end else begin
            oe_next_s  = 1'b0;
            out_next_s = {DATA_W{1'b0}};
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= FETCH_OP;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Instruction storage: opcode, operand words, count and fill index.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            opcode_r   <= {OPCODE_W{1'b0}};
            operands_r <= {(MAX_OPERANDS*DATA_W){1'b0}};
            count_r    <= {CNT_W{1'b0}};
            idx_r      <= {SEL_W{1'b0}};
        end else if (flush) begin
            count_r <= {CNT_W{1'b0}};
            idx_r   <= {SEL_W{1'b0}};
        end else begin
            case (state_r)
                FETCH_OP: begin
                    if (accept_s) begin
                        opcode_r   <= w_bus_in[OPCODE_W-1:0];
                        operands_r <= {(MAX_OPERANDS*DATA_W){1'b0}};
                        count_r    <= len_s;
                        idx_r      <= {SEL_W{1'b0}};
                    end
                end
                FETCH_ARG: begin
                    if (accept_s) begin
                        operands_r[32'(idx_r)*DATA_W +: DATA_W] <= w_bus_in;
                        if (!last_arg_s) begin
                            idx_r <= idx_r + {{(SEL_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered bus output stage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_oe_r  <= 1'b0;
            bus_out_r <= {DATA_W{1'b0}};
        end else begin
            bus_oe_r  <= oe_next_s;
            bus_out_r <= out_next_s;
        end
    end

endmodule

// File: tb/tb_sap_instruction_register_v2.sv
// Directed bench for the SAP instruction register: a 2-operand instance carries most
// vectors, a 1-operand instance covers the length clipping.
module tb_sap_instruction_register_v2;

    logic        clk;
    logic        rst_n;
    logic        flush, load_valid, instr_done, output_to_bus;
    logic [7:0]  w_bus_in;
    logic [0:0]  operand_sel;
    logic        load_ready, instr_valid, w_bus_oe;
    logic [7:0]  opcode, w_bus_out;
    logic [15:0] operands;
    logic [1:0]  operand_count;

    logic        lv1, done1, ready1, valid1, oe1;
    logic [7:0]  w1, opcode1, out1;
    logic [7:0]  operands1;
    logic [0:0]  count1;

    int n_tests = 0;
    int n_fail  = 0;

    sap_instruction_register_v2 #(.DATA_W(8), .OPCODE_W(8), .MAX_OPERANDS(2)) dut (
        .clock(clk), .reset(rst_n), .flush(flush), .w_bus_in(w_bus_in),
        .load_valid(load_valid), .load_ready(load_ready), .instr_done(instr_done),
        .output_to_bus(output_to_bus), .operand_sel(operand_sel), .opcode(opcode),
        .operands(operands), .operand_count(operand_count), .instr_valid(instr_valid),
        .w_bus_out(w_bus_out), .w_bus_oe(w_bus_oe)
    );

    sap_instruction_register_v2 #(.DATA_W(8), .OPCODE_W(8), .MAX_OPERANDS(1)) dut1 (
        .clock(clk), .reset(rst_n), .flush(1'b0), .w_bus_in(w1),
        .load_valid(lv1), .load_ready(ready1), .instr_done(done1),
        .output_to_bus(1'b0), .operand_sel(1'b0), .opcode(opcode1),
        .operands(operands1), .operand_count(count1), .instr_valid(valid1),
        .w_bus_out(out1), .w_bus_oe(oe1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; load_valid = 1'b0; instr_done = 1'b0;
        output_to_bus = 1'b0; w_bus_in = 8'h00; operand_sel = 1'b0;
        lv1 = 1'b0; done1 = 1'b0; w1 = 8'h00;
        #12;
        check_eq("rst_opcode", 32'(opcode), 32'h0);
        check_eq("rst_count", 32'(operand_count), 32'h0);
        check_eq("rst_valid", 32'(instr_valid), 32'h0);
        check_eq("rst_ready", 32'(load_ready), 32'h1);
        check_eq("rst_oe", 32'(w_bus_oe), 32'h0);
        rst_n = 1'b1;
        step();

        // 0-operand instruction
        load_valid = 1'b1; w_bus_in = 8'h1A;
        step();
        check_eq("op0_opcode", 32'(opcode), 32'h1A);
        check_eq("op0_count", 32'(operand_count), 32'h0);
        check_eq("op0_valid", 32'(instr_valid), 32'h1);
        check_eq("op0_ready", 32'(load_ready), 32'h0);
        load_valid = 1'b0; instr_done = 1'b1;
        step();
        check_eq("done_valid", 32'(instr_valid), 32'h0);
        instr_done = 1'b0;

        // 2-operand instruction with a 2-cycle stall
        load_valid = 1'b1; w_bus_in = 8'h8C;
        step();
        check_eq("op2_count", 32'(operand_count), 32'h2);
        check_eq("op2_valid_early", 32'(instr_valid), 32'h0);
        load_valid = 1'b0;
        step();
        step();
        check_eq("stall_valid", 32'(instr_valid), 32'h0);
        check_eq("stall_ready", 32'(load_ready), 32'h1);
        load_valid = 1'b1; w_bus_in = 8'h34;
        step();
        check_eq("arg0_valid", 32'(instr_valid), 32'h0);
        w_bus_in = 8'h12;
        step();
        check_eq("arg1_valid", 32'(instr_valid), 32'h1);
        check_eq("arg_operands", 32'(operands), 32'h1234);
        load_valid = 1'b0;

        // bus drive from HOLD
        output_to_bus = 1'b1; operand_sel = 1'b1;
        step();
        check_eq("drv1_oe", 32'(w_bus_oe), 32'h1);
        check_eq("drv1_out", 32'(w_bus_out), 32'h12);
        operand_sel = 1'b0;
        step();
        check_eq("drv0_out", 32'(w_bus_out), 32'h34);
        output_to_bus = 1'b0;
        load_valid = 1'b1; w_bus_in = 8'h55;
        step();
        check_eq("drv_off_oe", 32'(w_bus_oe), 32'h0);
        check_eq("drv_off_out", 32'(w_bus_out), 32'h0);
        check_eq("hold_ignores", 32'(opcode), 32'h8C);
        load_valid = 1'b0;

        // back-to-back: release then next opcode one cycle later
        instr_done = 1'b1;
        step();
        check_eq("b2b_ready", 32'(load_ready), 32'h1);
        instr_done = 1'b0; load_valid = 1'b1; w_bus_in = 8'h40;
        step();
        check_eq("b2b_opcode", 32'(opcode), 32'h40);
        check_eq("b2b_count", 32'(operand_count), 32'h1);
        check_eq("b2b_cleared", 32'(operands), 32'h0);
        w_bus_in = 8'h77;
        step();
        check_eq("b2b_valid", 32'(instr_valid), 32'h1);
        check_eq("b2b_operands", 32'(operands), 32'h0077);
        load_valid = 1'b0; output_to_bus = 1'b1; operand_sel = 1'b1;
        step();
        check_eq("oor_oe", 32'(w_bus_oe), 32'h0);
        check_eq("oor_out", 32'(w_bus_out), 32'h0);
        operand_sel = 1'b0;
        step();
        check_eq("inr_oe", 32'(w_bus_oe), 32'h1);
        check_eq("inr_out", 32'(w_bus_out), 32'h77);
        output_to_bus = 1'b0;

        // flush mid-fetch discards the offered word
        instr_done = 1'b1;
        step();
        instr_done = 1'b0; load_valid = 1'b1; w_bus_in = 8'h45;
        step();
        check_eq("fl_count_pre", 32'(operand_count), 32'h1);
        flush = 1'b1; w_bus_in = 8'h99;
        step();
        check_eq("fl_valid", 32'(instr_valid), 32'h0);
        check_eq("fl_count", 32'(operand_count), 32'h0);
        check_eq("fl_operands", 32'(operands), 32'h0);
        check_eq("fl_opcode_kept", 32'(opcode), 32'h45);
        check_eq("fl_ready", 32'(load_ready), 32'h1);
        flush = 1'b0; w_bus_in = 8'h03;
        step();
        check_eq("fl_next_opcode", 32'(opcode), 32'h03);
        check_eq("fl_next_valid", 32'(instr_valid), 32'h1);
        load_valid = 1'b0;

        // flush beats instr_done in HOLD
        flush = 1'b1; instr_done = 1'b1;
        step();
        check_eq("fd_valid", 32'(instr_valid), 32'h0);
        check_eq("fd_opcode", 32'(opcode), 32'h03);
        flush = 1'b0; instr_done = 1'b0;

        // async reset while holding and driving
        load_valid = 1'b1; w_bus_in = 8'hC1;
        step();
        w_bus_in = 8'hAA;
        step();
        w_bus_in = 8'hBB;
        step();
        load_valid = 1'b0; output_to_bus = 1'b1; operand_sel = 1'b0;
        step();
        check_eq("ar_pre_out", 32'(w_bus_out), 32'hAA);
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_opcode", 32'(opcode), 32'h0);
        check_eq("ar_operands", 32'(operands), 32'h0);
        check_eq("ar_valid", 32'(instr_valid), 32'h0);
        check_eq("ar_oe", 32'(w_bus_oe), 32'h0);
        check_eq("ar_out", 32'(w_bus_out), 32'h0);
        output_to_bus = 1'b0;
        #2 rst_n = 1'b1;
        step();
        check_eq("ar_ready", 32'(load_ready), 32'h1);

        // single-operand instance: 0xC0 clips to one operand
        lv1 = 1'b1; w1 = 8'hC0;
        step();
        check_eq("m1_count", 32'(count1), 32'h1);
        check_eq("m1_valid_early", 32'(valid1), 32'h0);
        w1 = 8'h5E;
        step();
        check_eq("m1_valid", 32'(valid1), 32'h1);
        check_eq("m1_operand", 32'(operands1), 32'h5E);
        lv1 = 1'b0; done1 = 1'b1;
        step();
        done1 = 1'b0; lv1 = 1'b1; w1 = 8'h40;
        step();
        check_eq("m1_b2b_opcode", 32'(opcode1), 32'h40);
        lv1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sap_instruction_register_v2.md
Name: sap_instruction_register_v2

Overview:
- Parametrised, variable-length instruction register for the next-generation SAP datapath.
- Fetches one opcode word plus 0..MAX_OPERANDS operand words from the W bus.
- Holds the complete instruction for the controller and drives a selected operand word back onto the bus.
- Bus is split into in/out/output-enable; top level performs bus muxing (no internal tri-states).

Parameters:
- DATA_W, 8, W bus width and width of each fetched word.
- OPCODE_W, 8, opcode width (≤ DATA_W); opcode = low OPCODE_W bits of first word.
- MAX_OPERANDS, 2, maximum operand words per instruction (≥ 1).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort; return to FETCH_OP.
- w_bus_in  in  DATA_W  word presented on the W bus.
- load_valid  in  1  controller offers a word on w_bus_in.
- load_ready  out  1  register accepts a word this cycle.
- instr_done  in  1  controller finished with the held instruction.
- output_to_bus  in  1  request to drive the selected operand.
- operand_sel  in  $clog2(MAX_OPERANDS) (min 1)  operand index to drive.
- opcode  out  OPCODE_W  held opcode.
- operands  out  MAX_OPERANDS*DATA_W  held operands; operand k at bits [k*DATA_W +: DATA_W].
- operand_count  out  $clog2(MAX_OPERANDS+1)  operand count of the held instruction.
- instr_valid  out  1  complete instruction held.
- w_bus_out  out  DATA_W  registered bus drive value.
- w_bus_oe  out  1  registered bus output enable.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = FETCH_OP.
  - opcode, operands, operand_count, internal index, w_bus_out, w_bus_oe all 0.
  - instr_valid=0.
- Handshake: a word is accepted on a rising edge with load_valid && load_ready.
  - load_ready=1 in FETCH_OP and FETCH_ARG; 0 in HOLD.
- Operand count is decoded from the top 2 opcode bits by op_len():
  - 00 → 0, 01 → 1, 1x → 2.
  - Result is clipped to MAX_OPERANDS.
- FETCH_OP:
  - On accept: opcode ← w_bus_in[OPCODE_W-1:0]; operand_count ← op_len; index ← 0; operands cleared to 0.
  - If the count is 0, go to HOLD; otherwise go to FETCH_ARG.
- FETCH_ARG:
  - On accept: operands[index] ← w_bus_in.
  - If index == operand_count-1, go to HOLD; otherwise index++.
  - No accept: hold all values.
- HOLD:
  - instr_valid=1, taken combinationally from state.
  - On instr_done, go to FETCH_OP; instr_valid=0 next cycle.
  - load_valid is ignored while in HOLD (load_ready=0).
- flush: synchronous, highest priority in every state.
  - Go to FETCH_OP, index ← 0, operand_count ← 0; instr_valid drops next cycle.
  - Any word offered in the same cycle is discarded.
  - opcode and operands keep their values until the next opcode accept.
- flush and instr_done together: flush wins (same result).
- Bus drive: registered, 1-cycle latency.
  - Next cycle w_bus_oe = output_to_bus && state==HOLD && operand_sel < operand_count.
  - Next cycle w_bus_out = operands[operand_sel] when w_bus_oe is 1, otherwise 0.
  - An out-of-range operand_sel gives oe=0, out=0.
- Width rule: if OPCODE_W < DATA_W, the upper opcode-word bits are discarded.
- Reset mid-fetch: immediate return to the reset state; the partial instruction is lost.

Decomposition:
- Shared package sap_pkg:
  - typedef enum ir_state_t {FETCH_OP, FETCH_ARG, HOLD}.
  - Function op_len(opcode, max) implementing the length decode above, so the controller reuses the same decode.
  - Default constants SAP_DATA_W=8 and SAP_OPCODE_W=8.
- No sub-module needed: single module, one FSM plus the operand array.

Test Plan:
- Reset then 0-operand fetch:
  - Offer 0x1A with load_valid=1.
  - Next cycle: opcode=0x1A, operand_count=0, instr_valid=1, load_ready=0.
- 2-operand fetch with stall:
  - Offer 0x8C, then deassert load_valid for 2 cycles, then offer 0x34, then 0x12.
  - Result: operands={0x12,0x34}; instr_valid rises only after 0x12 is accepted.
- Bus drive:
  - In HOLD with count=2, operand_sel=1 and output_to_bus=1.
  - Next cycle: w_bus_oe=1, w_bus_out=0x12.
  - With operand_sel=1 on a 1-operand instruction: w_bus_oe=0, w_bus_out=0.
- flush mid-fetch:
  - Accept 0x45 (1 operand), then raise flush together with load_valid and 0x99.
  - Result: state FETCH_OP, word 0x99 not stored, instr_valid stays 0.
  - Next accepted word is treated as an opcode.
- Async reset in HOLD:
  - Pull reset low mid-cycle.
  - Outputs go to 0 immediately, before the next clock edge; load_ready=1 after release.
- Back-to-back:
  - Assert instr_done in HOLD; offer the next opcode 0x40 in the following cycle.
  - Result: accepted; a 1-cycle gap minimum between instructions is verified.
  - Repeat with MAX_OPERANDS=1: opcode 0xC0 yields operand_count=1.
